tb_mmio_responder: RTL and testbench
====================================

Name: tb_mmio_responder

Overview:
- Memory-mapped testbench control peripheral and the responder end of the core data-bus requests that drive the simulation top's pass/fail/exit/stdout signals.
- Sits in the simulation wrapper beside the dual-port RAM; the wrapper routes data-bus requests whose address falls in the BASE_ADDR window here.
- Buffers characters for stdout, latches exit code and pass/fail signature, and exposes a 64-bit cycle counter.

Parameters:
- BASE_ADDR, 32'h1000_0000, byte address of register window (4 KiB aligned).
- FIFO_DEPTH, 8, stdout character FIFO entries; power of two, >= 2.
- PASS_SIGNATURE, 32'd123456789, SIGNATURE value that raises tests_passed_o.
- FAIL_SIGNATURE, 32'd1, SIGNATURE value that raises tests_failed_o.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- data_req_i  in  1  request valid; held with attributes until granted
- data_gnt_o  out  1  grant, combinational
- data_addr_i  in  32  byte address
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  response valid, for reads and writes
- data_rdata_o  out  32  read data, 0 for writes
- char_valid_o  out  1  stdout character available
- char_o  out  8  character at FIFO head
- char_ready_i  in  1  sink accepts character
- tests_passed_o  out  1  sticky pass flag
- tests_failed_o  out  1  sticky fail flag
- exit_valid_o  out  1  sticky exit flag
- exit_value_o  out  32  exit code

Behaviour:
- Reset (rst_ni low at posedge):
  - All outputs 0, FIFO empty, counter 0, shadow 0.
  - Any pending response is dropped; no rvalid in the cycle after reset deasserts.
- Hit: data_req_i && data_addr_i[31:12] == BASE_ADDR[31:12]. The register is selected by data_addr_i[11:2].
- Grant:
  - data_gnt_o = hit, except a PRINT write while the FIFO is full, which gives gnt = 0 (stall).
  - A pop in the same cycle does not lift the stall.
  - Non-hit requests are never granted.
- Response:
  - Exactly one cycle after each grant: data_rvalid_o = 1 for one cycle, with data_rdata_o registered.
  - Back-to-back grants give back-to-back rvalids.
  - data_rdata_o holds its value when rvalid = 0.
- Register map (offset, read / write):
  - 0x00 PRINT:
    - Read = {28'b0, fill level} (level width log2(FIFO_DEPTH)+1, zero-extended).
    - Write with be[0] = 1 pushes wdata[7:0]; with be[0] = 0 the write is ignored but still acked.
  - 0x04 EXIT:
    - Read = exit_value_o.
    - First write sets exit_value_o = wdata with disabled byte lanes zeroed, and exit_valid_o = 1 from the next cycle.
    - Later writes are ignored (first wins).
  - 0x08 SIGNATURE:
    - Read = {30'b0, tests_failed_o, tests_passed_o}.
    - Full-word write (be = 4'hF) equal to PASS_SIGNATURE sets tests_passed_o.
    - Full-word write equal to FAIL_SIGNATURE sets tests_failed_o.
    - Other values, and partial-be writes, are ignored.
    - Both flags are sticky and may both be set.
  - 0x0C CYCLE_LO:
    - Read returns counter[31:0] sampled in the grant cycle, and latches counter[63:32] into the shadow in the same cycle.
    - Writes are ignored.
  - 0x10 CYCLE_HI: read returns the shadow; writes are ignored.
  - Other offsets: read 0, writes ignored, still acked.
- Counter: 64-bit, increments every cycle out of reset, wraps 2^64-1 -> 0.
- FIFO:
  - char_valid_o = !empty; char_o = head entry.
  - Pop when char_valid_o && char_ready_i.
  - Push and pop in the same cycle when not full: level unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH; the full/empty distinction uses an extra pointer bit.
  - A character is visible on char_o the cycle after its grant.

Test Plan:
- Reset, then read 0x0C at cycle 10 and 0x10 -> rdata_lo = 10 (± fixed offset, deterministic), rdata_hi = 0; rvalid exactly 1 cycle after each gnt.
- Write 'H', 'i' to PRINT with char_ready_i = 0 -> char_valid_o = 1, char_o = 8'h48; PRINT read = 2; raise ready -> 8'h48 then 8'h69 pop, then valid = 0.
- FIFO_DEPTH = 8: hold ready = 0, issue 9 PRINT writes -> 9th gnt = 0 until one pop; pop in the stalled cycle still gives gnt = 0, and the write is granted the following cycle.
- Write EXIT = 32'h0000_0003 with be = 4'hF, then EXIT = 32'h5 -> exit_valid_o = 1, exit_value_o stays 3; be = 4'h1 first write of 32'hAABBCC07 -> value 32'h0000_0007.
- Write SIGNATURE 123456789 -> tests_passed_o = 1 next cycle; write 7 -> no change; write 1 with be = 4'h3 -> ignored; read 0x08 -> 32'h1.
- Assert rst_ni low the cycle after a granted read -> no rvalid, all flags 0, FIFO empty; access to offset 0x40 -> acked, rdata 0; address outside window -> gnt 0.

Source files
------------

// File: rtl/tb_mmio_responder.sv
// tb_mmio_responder
// Memory-mapped control peripheral for the simulation top. It answers data-bus
// requests that fall in a 4 KiB window at BASE_ADDR. It buffers stdout characters
// in a small FIFO and latches the program's exit code and pass/fail signature.
// It also exposes a free-running 64-bit cycle counter.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   data_req_i/data_gnt_o    request handshake (grant is combinational)
//   data_addr_i/we/be/wdata  request attributes, held until granted
//   data_rvalid_o/rdata_o    one-cycle response, exactly one cycle after grant
//   char_valid_o/char_o      stdout FIFO head, popped when char_ready_i is high
//   tests_passed_o/failed_o  sticky signature flags
//   exit_valid_o/value_o     first-write-wins exit code
module tb_mmio_responder #(
   parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter logic [31:0] PASS_SIGNATURE = 32'd123456789,
   parameter logic [31:0] FAIL_SIGNATURE = 32'd1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        char_valid_o,
   output logic [7:0]  char_o,
   input  logic        char_ready_i,
   output logic        tests_passed_o,
   output logic        tests_failed_o,
   output logic        exit_valid_o,
   output logic [31:0] exit_value_o
);

   localparam int unsigned    PTR_W      = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] PTR_ONE    = 1;
   localparam logic [9:0]     REG_PRINT  = 10'd0;
   localparam logic [9:0]     REG_EXIT   = 10'd1;
   localparam logic [9:0]     REG_SIG    = 10'd2;
   localparam logic [9:0]     REG_CYC_LO = 10'd3;
   localparam logic [9:0]     REG_CYC_HI = 10'd4;

   logic [9:0]     reg_idx;
   logic           hit;
   logic           print_wr;
   logic           push;
   logic           pop;
   logic           empty;
   logic           full;
   logic [PTR_W:0] level;
   logic [31:0]    rd_val;
   logic [31:0]    be_mask;
   logic           unused_addr_bits;

   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]     mem_q [FIFO_DEPTH];
   logic [7:0]     mem_d [FIFO_DEPTH];
   logic           rvalid_q, rvalid_d;
   logic [31:0]    rdata_q, rdata_d;
   logic [63:0]    counter_q, counter_d;
   logic [31:0]    shadow_q, shadow_d;
   logic           exit_valid_q, exit_valid_d;
   logic [31:0]    exit_value_q, exit_value_d;
   logic           passed_q, passed_d;
   logic           failed_q, failed_d;

   // Word-aligned registers only; the byte offset within a word is don't-care.
   assign unused_addr_bits = ^data_addr_i[1:0];

   assign reg_idx  = data_addr_i[11:2];
   assign hit      = data_req_i && (data_addr_i[31:12] == BASE_ADDR[31:12]);
   assign print_wr = data_we_i && (reg_idx == REG_PRINT);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign level = wr_ptr_q - rd_ptr_q;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   // A PRINT write into a full FIFO stalls; a same-cycle pop deliberately does
   // not lift the stall so grant never depends on the sink's ready.
   assign data_gnt_o = rst_ni && hit && !(print_wr && full);
   assign push       = data_gnt_o && print_wr && data_be_i[0];
   assign pop        = char_valid_o && char_ready_i;

   assign char_valid_o   = !empty;
   assign char_o         = empty ? 8'h00 : mem_q[rd_ptr_q[PTR_W-1:0]];
   assign data_rvalid_o  = rvalid_q && rst_ni;
   assign data_rdata_o   = rdata_q;
   assign tests_passed_o = passed_q;
   assign tests_failed_o = failed_q;
   assign exit_valid_o   = exit_valid_q;
   assign exit_value_o   = exit_value_q;

   assign be_mask = {{8{data_be_i[3]}}, {8{data_be_i[2]}},
                     {8{data_be_i[1]}}, {8{data_be_i[0]}}};

   // Read mux, evaluated in the grant cycle and registered into the response.
   always_comb begin
      rd_val = 32'h0;
      case (reg_idx)
         REG_PRINT:  rd_val = 32'(level);
         REG_EXIT:   rd_val = exit_value_q;
         REG_SIG:    rd_val = {30'b0, failed_q, passed_q};
         REG_CYC_LO: rd_val = counter_q[31:0];
         REG_CYC_HI: rd_val = shadow_q;
         default:    rd_val = 32'h0;
      endcase
   end

   // Next-state logic for the response path, registers, counter and FIFO.
   always_comb begin
      rvalid_d     = data_gnt_o;
      rdata_d      = rdata_q;
      counter_d    = counter_q + 64'd1;
      shadow_d     = shadow_q;
      exit_valid_d = exit_valid_q;
      exit_value_d = exit_value_q;
      passed_d     = passed_q;
      failed_d     = failed_q;
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;

      if (data_gnt_o) begin
         rdata_d = data_we_i ? 32'h0 : rd_val;
         // Reading the low half snapshots the high half so a LO/HI pair is coherent.
         if (!data_we_i && (reg_idx == REG_CYC_LO)) begin
            shadow_d = counter_q[63:32];
         end
         if (data_we_i) begin
            case (reg_idx)
               REG_EXIT: begin
                  if (!exit_valid_q) begin
                     exit_valid_d = 1'b1;
                     exit_value_d = data_wdata_i & be_mask;
                  end
               end
               REG_SIG: begin
                  if (data_be_i == 4'hF) begin
                     if (data_wdata_i == PASS_SIGNATURE) passed_d = 1'b1;
                     if (data_wdata_i == FAIL_SIGNATURE) failed_d = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end

      if (push) begin
         mem_d[wr_ptr_q[PTR_W-1:0]] = data_wdata_i[7:0];
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   // State registers with synchronous reset; reset also drops any pending response.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rvalid_q     <= 1'b0;
         rdata_q      <= 32'h0;
         counter_q    <= 64'h0;
         shadow_q     <= 32'h0;
         exit_valid_q <= 1'b0;
         exit_value_q <= 32'h0;
         passed_q     <= 1'b0;
         failed_q     <= 1'b0;
         mem_q        <= '{default: 8'h00};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;
         counter_q    <= counter_d;
         shadow_q     <= shadow_d;
         exit_valid_q <= exit_valid_d;
         exit_value_q <= exit_value_d;
         passed_q     <= passed_d;
         failed_q     <= failed_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
      end
   end

endmodule

// File: tb/tb_tb_mmio_responder.sv
// tb_tb_mmio_responder
// Bench for tb_mmio_responder. A driver issues directed and random bus accesses.
// A reference model predicts grants, sticky flags, the exit code and the stdout
// character stream. Expected read responses are queued with the cycle they are
// due in, and an independent monitor pops and compares them when rvalid appears.
module tb_tb_mmio_responder;

   localparam logic [31:0] BASE_ADDR      = 32'h1000_0000;
   localparam int unsigned FIFO_DEPTH     = 8;
   localparam logic [31:0] PASS_SIGNATURE = 32'd123456789;
   localparam logic [31:0] FAIL_SIGNATURE = 32'd1;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        data_req_i;
   logic        data_gnt_o;
   logic [31:0] data_addr_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_wdata_i;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        char_valid_o;
   logic [7:0]  char_o;
   logic        char_ready_i;
   logic        tests_passed_o;
   logic        tests_failed_o;
   logic        exit_valid_o;
   logic [31:0] exit_value_o;

   int vectors    = 0;
   int miscompares = 0;
   int tb_cycle   = 0;
   bit rand_ready = 0;

   // Reference model state
   exp_t            exp_q[$];
   byte unsigned    fifo_m[$];
   longint unsigned cyc_model = 0;
   logic [31:0]     shadow_m;
   logic [31:0]     exit_value_m;
   bit              exit_valid_m;
   bit              passed_m;
   bit              failed_m;
   logic [31:0]     last_rdata = 32'h0;

   tb_mmio_responder #(
      .BASE_ADDR      (BASE_ADDR),
      .FIFO_DEPTH     (FIFO_DEPTH),
      .PASS_SIGNATURE (PASS_SIGNATURE),
      .FAIL_SIGNATURE (FAIL_SIGNATURE)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .data_req_i     (data_req_i),
      .data_gnt_o     (data_gnt_o),
      .data_addr_i    (data_addr_i),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_wdata_i   (data_wdata_i),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .char_valid_o   (char_valid_o),
      .char_o         (char_o),
      .char_ready_i   (char_ready_i),
      .tests_passed_o (tests_passed_o),
      .tests_failed_o (tests_failed_o),
      .exit_valid_o   (exit_valid_o),
      .exit_value_o   (exit_value_o)
   );

   always #5 clk_i = ~clk_i;

   // Cycle bookkeeping: the expected counter value is simply the number of
   // clock edges seen since reset was last released.
   always @(posedge clk_i) begin
      tb_cycle <= tb_cycle + 1;
      if (!rst_ni) cyc_model <= 64'd0;
      else         cyc_model <= cyc_model + 64'd1;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, tb_cycle);
      end
   endtask

   task automatic clearModel();
      fifo_m.delete();
      shadow_m     = 32'h0;
      exit_value_m = 32'h0;
      exit_valid_m = 0;
      passed_m     = 0;
      failed_m     = 0;
   endtask

   // One clock cycle: inputs are already applied just after the negedge.
   // Compares grant and persistent outputs, then advances the model.
   task automatic tick(output bit granted);
      bit          exp_gnt;
      bit          hit;
      bit          do_push;
      int          reg_n;
      logic [31:0] off;
      logic [31:0] rd;
      logic [31:0] v;
      #1;
      hit   = data_req_i && (data_addr_i >= BASE_ADDR) && (data_addr_i < BASE_ADDR + 32'd4096);
      off   = data_addr_i - BASE_ADDR;
      reg_n = int'(off >> 2);
      if (!rst_ni) exp_gnt = 0;
      else         exp_gnt = hit && !(data_we_i && reg_n == 0 && fifo_m.size() == FIFO_DEPTH);
      checkOutput("gnt", data_gnt_o, exp_gnt);
      granted = (data_gnt_o === 1'b1);
      do_push = 0;
      if (rst_ni) begin
         checkOutput("tests_passed", tests_passed_o, passed_m);
         checkOutput("tests_failed", tests_failed_o, failed_m);
         checkOutput("exit_valid", exit_valid_o, exit_valid_m);
         checkOutput("exit_value", exit_value_o, exit_value_m);
         checkOutput("char_valid", char_valid_o, fifo_m.size() != 0);
         if (fifo_m.size() != 0) checkOutput("char_o", char_o, fifo_m[0]);
         if (exp_gnt) begin
            rd = 32'h0;
            if (!data_we_i) begin
               case (reg_n)
                  0: rd = fifo_m.size();
                  1: rd = exit_value_m;
                  2: rd = {30'b0, failed_m, passed_m};
                  3: begin
                     rd       = cyc_model[31:0];
                     shadow_m = cyc_model[63:32];
                  end
                  4: rd = shadow_m;
                  default: rd = 32'h0;
               endcase
            end else begin
               case (reg_n)
                  0: do_push = data_be_i[0];
                  1: if (!exit_valid_m) begin
                     v = 32'h0;
                     for (int b = 0; b < 4; b++) if (data_be_i[b]) v[8*b +: 8] = data_wdata_i[8*b +: 8];
                     exit_value_m = v;
                     exit_valid_m = 1;
                  end
                  2: if (data_be_i == 4'hF) begin
                     if (data_wdata_i == PASS_SIGNATURE) passed_m = 1;
                     if (data_wdata_i == FAIL_SIGNATURE) failed_m = 1;
                  end
                  default: ;
               endcase
            end
            exp_q.push_back('{data: rd, due: tb_cycle + 1});
         end
         if (char_ready_i && fifo_m.size() != 0) void'(fifo_m.pop_front());
         if (do_push) fifo_m.push_back(data_wdata_i[7:0]);
      end else begin
         clearModel();
      end
      @(negedge clk_i);
   endtask

   task automatic setReq(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
      data_req_i   = 1'b1;
      data_addr_i  = a;
      data_we_i    = we;
      data_be_i    = be;
      data_wdata_i = wd;
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
      bit g;
      int n;
      g = 0;
      n = 0;
      setReq(a, we, be, wd);
      while (!g && n < 64) begin
         if (rand_ready) char_ready_i = 1'($urandom_range(0, 1));
         tick(g);
         n++;
      end
      data_req_i = 1'b0;
      checkOutput("grant_within_budget", g, 1);
   endtask

   // Responses due from the current cycle on are dropped by the reset.
   task automatic doReset(input int n);
      bit g;
      data_req_i = 1'b0;
      rst_ni     = 1'b0;
      while (exp_q.size() != 0 && exp_q[$].due >= tb_cycle) void'(exp_q.pop_back());
      repeat (n) tick(g);
      rst_ni = 1'b1;
   endtask

   // Response monitor, sampling later in the cycle than the driver's checks.
   always begin : monitor
      exp_t e;
      @(negedge clk_i);
      #2;
      while (exp_q.size() != 0 && exp_q[0].due < tb_cycle) begin
         e = exp_q.pop_front();
         checkOutput("rvalid_missing", 1'b0, 1'b1);
      end
      if (exp_q.size() != 0 && exp_q[0].due == tb_cycle) begin
         e = exp_q.pop_front();
         checkOutput("rvalid", data_rvalid_o, 1'b1);
         checkOutput("rdata", data_rdata_o, e.data);
         last_rdata = data_rdata_o;
      end else if (data_rvalid_o !== 1'b0) begin
         checkOutput("rvalid_unexpected", data_rvalid_o, 1'b0);
      end else if (!rst_ni) begin
         last_rdata = 32'h0;
      end else begin
         checkOutput("rdata_hold", data_rdata_o, last_rdata);
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit g;
      rst_ni       = 1'b0;
      data_req_i   = 1'b0;
      data_addr_i  = 32'h0;
      data_we_i    = 1'b0;
      data_be_i    = 4'h0;
      data_wdata_i = 32'h0;
      char_ready_i = 1'b0;
      clearModel();
      @(negedge clk_i);
      doReset(2);

      // Cycle counter read pair shortly after reset
      repeat (8) tick(g);
      applyStimulus(BASE_ADDR + 32'h0C, 1'b0, 4'hF, 32'h0);
      applyStimulus(BASE_ADDR + 32'h10, 1'b0, 4'hF, 32'h0);

      // "Hi" buffered while the sink is not ready, then drained
      applyStimulus(BASE_ADDR, 1'b1, 4'hF, 32'h48);
      applyStimulus(BASE_ADDR, 1'b1, 4'hF, 32'h69);
      checkOutput("char_head_H", char_o, 8'h48);
      applyStimulus(BASE_ADDR, 1'b0, 4'hF, 32'h0);
      char_ready_i = 1'b1;
      repeat (4) tick(g);
      char_ready_i = 1'b0;
      checkOutput("char_drained", char_valid_o, 1'b0);

      // Fill the FIFO and stall the ninth write
      for (int i = 0; i < 8; i++) applyStimulus(BASE_ADDR, 1'b1, 4'hF, 32'h41 + i);
      setReq(BASE_ADDR, 1'b1, 4'hF, 32'h5A);
      repeat (3) begin
         tick(g);
         checkOutput("full_stall_gnt", g, 1'b0);
      end
      char_ready_i = 1'b1;
      tick(g);
      checkOutput("pop_cycle_stall_gnt", g, 1'b0);
      char_ready_i = 1'b0;
      tick(g);
      checkOutput("unstall_gnt", g, 1'b1);
      data_req_i   = 1'b0;
      char_ready_i = 1'b1;
      repeat (10) tick(g);
      char_ready_i = 1'b0;

      // Exit code: first write wins, disabled lanes zeroed
      doReset(1);
      applyStimulus(BASE_ADDR + 32'h04, 1'b1, 4'hF, 32'h0000_0003);
      applyStimulus(BASE_ADDR + 32'h04, 1'b1, 4'hF, 32'h0000_0005);
      tick(g);
      checkOutput("exit_first_wins", exit_value_o, 32'h3);
      doReset(1);
      applyStimulus(BASE_ADDR + 32'h04, 1'b1, 4'h1, 32'hAABB_CC07);
      tick(g);
      checkOutput("exit_masked", exit_value_o, 32'h7);

      // Signature handling
      applyStimulus(BASE_ADDR + 32'h08, 1'b1, 4'hF, PASS_SIGNATURE);
      checkOutput("passed_next_cycle", tests_passed_o, 1'b1);
      applyStimulus(BASE_ADDR + 32'h08, 1'b1, 4'hF, 32'd7);
      applyStimulus(BASE_ADDR + 32'h08, 1'b1, 4'h3, FAIL_SIGNATURE);
      applyStimulus(BASE_ADDR + 32'h08, 1'b0, 4'hF, 32'h0);
      tick(g);
      checkOutput("failed_unset", tests_failed_o, 1'b0);

      // Reset right after a granted read, then unmapped and out-of-window access
      applyStimulus(BASE_ADDR + 32'h08, 1'b0, 4'hF, 32'h0);
      doReset(1);
      tick(g);
      checkOutput("flag_after_reset", tests_passed_o, 1'b0);
      applyStimulus(BASE_ADDR + 32'h40, 1'b0, 4'hF, 32'h0);
      setReq(BASE_ADDR + 32'h1000, 1'b0, 4'hF, 32'h0);
      tick(g);
      checkOutput("out_of_window_gnt", g, 1'b0);
      data_req_i = 1'b0;

      // Randomized traffic with a randomly ready sink
      rand_ready = 1;
      for (int it = 0; it < 300; it++) begin
         int          kind;
         int          sel;
         logic [31:0] wd;
         logic [3:0]  be;
         kind = $urandom_range(0, 10);
         sel  = $urandom_range(0, 2);
         wd   = $urandom;
         be   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         case (kind)
            0, 1, 2: applyStimulus(BASE_ADDR, 1'b1, be, wd);
            3: applyStimulus(BASE_ADDR, 1'b0, 4'hF, 32'h0);
            4: applyStimulus(BASE_ADDR + 32'h04, 1'b1, be, wd);
            5: applyStimulus(BASE_ADDR + 32'h08, 1'b1, be,
                             (sel == 0) ? PASS_SIGNATURE : (sel == 1) ? FAIL_SIGNATURE : wd);
            6: begin
               applyStimulus(BASE_ADDR + 32'h0C, 1'b0, 4'hF, 32'h0);
               applyStimulus(BASE_ADDR + 32'h10, 1'b0, 4'hF, 32'h0);
            end
            7: applyStimulus(BASE_ADDR + 32'(4 * $urandom_range(1, 20)), 1'b0, 4'hF, 32'h0);
            8: applyStimulus(BASE_ADDR + 32'(4 * $urandom_range(3, 20)), 1'b1, be, wd);
            9: begin
               setReq((sel == 0) ? BASE_ADDR + 32'h1000 : 32'h2000_0000 + 32'($urandom_range(0, 4095)),
                      1'($urandom_range(0, 1)), be, wd);
               char_ready_i = 1'($urandom_range(0, 1));
               tick(g);
               checkOutput("random_out_of_window_gnt", g, 1'b0);
               data_req_i = 1'b0;
            end
            default: begin
               char_ready_i = 1'($urandom_range(0, 1));
               tick(g);
            end
         endcase
         if ($urandom_range(0, 79) == 0) doReset(1);
      end

      rand_ready   = 0;
      data_req_i   = 1'b0;
      char_ready_i = 1'b1;
      repeat (12) tick(g);
      checkOutput("responses_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
